fp_wb_scoreboard: RTL and testbench
===================================

FP_WB_SCOREBOARD -- requirements
Module: fp_wb_scoreboard

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset; low clears all state immediately.
REQ-003 SHALL have ports issue_valid  input  1; issue_frs, issue_frt, issue_frd  input  5 each; issue_wr  input  1: decoded FP instruction and whether it writes issue_frd.
REQ-004 SHALL have port issue_stall  output  1  combinational hazard stall to decode.
REQ-005 SHALL have ports alu_valid  input  1; alu_dst  input  5; alu_data  input  32; alu_ready  output  1: FP ALU writeback request.
REQ-006 SHALL have ports ld_valid  input  1; ld_dst  input  5; ld_data  input  32; ld_ready  output  1: FP load (lwc1) writeback request.
REQ-007 SHALL have ports fp_write  output  1; frd  output  5; fp_write_data  output  32: registered drive of the FP register file write port.
REQ-008 SHALL have port busy  output  32  pending-write bit per $f register.
REQ-009 SHALL have port conflict_cnt  output  16  count of cycles with both requesters valid.

Function
REQ-010 Issue accepted SHALL mean issue_valid=1 and issue_stall=0.
REQ-011 issue_stall SHALL be issue_valid & (busy[issue_frs] | busy[issue_frt] | (issue_wr & busy[issue_frd])).
REQ-012 Accepted issue with issue_wr=1 and issue_frd!=0 SHALL set busy[issue_frd] at the next edge; busy[0] SHALL always read 0.
REQ-013 Arbiter SHALL grant at most one requester per cycle; lone valid requester SHALL be granted that cycle.
REQ-014 When both valid, grant SHALL go to the requester not granted most recently (round-robin bit last_ld, reset 1 so ALU wins first contention).
REQ-015 alu_ready/ld_ready SHALL equal the combinational grant; a request transfers on valid & ready; last_ld SHALL update only on a transfer.
REQ-016 A transfer SHALL load fp_write=(dst!=0), frd=dst, fp_write_data=data at the next edge; with no transfer fp_write SHALL be 0 next cycle and frd/fp_write_data SHALL hold.
REQ-017 Latency: request granted in cycle N -> fp_write high in cycle N+1 -> register file written at end of N+1.
REQ-018 busy[frd] SHALL clear at the edge ending a cycle where fp_write=1 (same edge the register file captures).
REQ-019 Simultaneous set (REQ-012) and clear (REQ-018) of the same bit SHALL leave it set.
REQ-020 Requests with dst=0 SHALL be accepted and discarded (fp_write stays 0, busy unchanged).
REQ-021 A request whose dst bit is not busy SHALL still be written (no filtering); the scoreboard only tracks.
REQ-022 conflict_cnt SHALL increment when alu_valid & ld_valid, saturating at 16'hFFFF.
REQ-023 Requester data/dst SHALL be held stable by the requester while valid and not ready.

Reset
REQ-024 On reset low: busy=0, fp_write=0, frd=0, fp_write_data=0, last_ld=1, conflict_cnt=0, asynchronously.
REQ-025 While reset low, alu_ready=ld_ready=0 and issue_stall=0; no transfer or busy update shall occur.
REQ-026 Reset asserted mid-transfer SHALL drop the pending write; first edge after release SHALL behave as post-reset idle.

Verification
REQ-027 Issue frd=3 write, then next cycle issue frs=3 -> issue_stall=1; ALU writes dst=3 data 32'h40400000 -> fp_write high one cycle later, busy[3] clears at that edge, stall drops next cycle.
REQ-028 ALU and load both valid for 3 cycles (dst 4, 5, 6/7) -> grants ALU, LD, ALU; conflict_cnt=3.
REQ-029 Issue frd=0 write -> busy stays 0; load dst=0 data 32'hDEADBEEF -> ld_ready=1, fp_write never asserts.
REQ-030 busy[9] clearing and new issue frd=9 in same cycle -> busy[9]=1 after edge; subsequent issue with frt=9 stalls.
REQ-031 Assert reset low mid-cycle with busy=32'h0000_0410 and transfer pending -> busy=0, fp_write=0 immediately, conflict_cnt=0, first contention after release grants ALU.

Source files
------------

// File: rtl/fp_wb_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : fp_wb_scoreboard
//  Description : FP register-file writeback arbiter plus pending-write
//                scoreboard. Tracks which $f registers have a write in
//                flight, stalls decode on RAW/WAW hazards, and arbitrates
//                the single register-file write port between the FP ALU
//                and FP load requesters with a round-robin tie-break.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   1   clock, all state on rising edge
//    reset          in   1   asynchronous active-low reset
//    issue_valid    in   1   decoded FP instruction present
//    issue_frs/frt  in   5   source registers of the instruction
//    issue_frd      in   5   destination register of the instruction
//    issue_wr       in   1   instruction writes issue_frd
//    issue_stall    out  1   hazard stall back to decode (combinational)
//    alu_valid/dst/data  in  FP ALU writeback request
//    alu_ready      out  1   ALU request granted this cycle
//    ld_valid/dst/data   in  FP load writeback request
//    ld_ready       out  1   load request granted this cycle
//    fp_write       out  1   register-file write enable (registered)
//    frd            out  5   register-file write address (registered)
//    fp_write_data  out  32  register-file write data (registered)
//    busy           out  32  pending-write bit per $f register
//    conflict_cnt   out  16  saturating count of contention cycles
// ============================================================================
module fp_wb_scoreboard (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic [4:0]  issue_frs,
    input  logic [4:0]  issue_frt,
    input  logic [4:0]  issue_frd,
    input  logic        issue_wr,
    output logic        issue_stall,
    input  logic        alu_valid,
    input  logic [4:0]  alu_dst,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        ld_valid,
    input  logic [4:0]  ld_dst,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    output logic        fp_write,
    output logic [4:0]  frd,
    output logic [31:0] fp_write_data,
    output logic [31:0] busy,
    output logic [15:0] conflict_cnt
);

    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic [31:0] r_busy;
    logic        r_fp_write;
    logic [4:0]  r_frd;
    logic [31:0] r_wdata;
    logic        r_last_ld;
    logic [15:0] r_conflict_cnt;

    logic        w_hazard;
    logic        w_issue_acc;
    logic        w_both;
    logic        w_alu_gnt;
    logic        w_ld_gnt;
    logic [31:0] w_busy_set;
    logic [31:0] w_busy_clr;
    logic [31:0] w_busy_nxt;

    // Hazard on any busy source, or on a busy destination when writing.
    assign w_hazard    = issue_valid & (r_busy[issue_frs] | r_busy[issue_frt] |
                                        (issue_wr & r_busy[issue_frd]));
    assign w_issue_acc = issue_valid & ~w_hazard;

    // Round-robin: on contention the side that did not win last goes.
    // r_last_ld=1 means the load side won most recently.
    assign w_both    = alu_valid & ld_valid;
    assign w_alu_gnt = alu_valid & (~ld_valid | r_last_ld);
    assign w_ld_gnt  = ld_valid  & (~alu_valid | ~r_last_ld);

    // Outputs are forced quiet while reset is held; internal state is held
    // by the asynchronous reset anyway, so the raw terms suffice internally.
    assign issue_stall = w_hazard  & reset;
    assign alu_ready   = w_alu_gnt & reset;
    assign ld_ready    = w_ld_gnt  & reset;

    // Clear happens on the same edge the register file captures the write.
    // Set is applied after clear so a coincident set/clear leaves the bit set.
    always_comb begin
        w_busy_clr = '0;
        w_busy_set = '0;
        if (r_fp_write) begin
            w_busy_clr[r_frd] = 1'b1;
        end
        if (w_issue_acc && issue_wr && (issue_frd != 5'd0)) begin
            w_busy_set[issue_frd] = 1'b1;
        end
        w_busy_nxt    = (r_busy & ~w_busy_clr) | w_busy_set;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy         <= '0;
            r_fp_write     <= 1'b0;
            r_frd          <= '0;
            r_wdata        <= '0;
            r_last_ld      <= 1'b1;
            r_conflict_cnt <= '0;
        end else begin
            r_busy <= w_busy_nxt;

            if (w_alu_gnt) begin
                r_fp_write <= (alu_dst != 5'd0);
                r_frd      <= alu_dst;
                r_wdata    <= alu_data;
                r_last_ld  <= 1'b0;
            end else if (w_ld_gnt) begin
                r_fp_write <= (ld_dst != 5'd0);
                r_frd      <= ld_dst;
                r_wdata    <= ld_data;
                r_last_ld  <= 1'b1;
            end else begin
                r_fp_write <= 1'b0;
            end

            if (w_both && (r_conflict_cnt != c_CNT_MAX)) begin
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
            end
        end
    end

    assign fp_write      = r_fp_write;
    assign frd           = r_frd;
    assign fp_write_data = r_wdata;
    assign busy          = r_busy;
    assign conflict_cnt  = r_conflict_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fp_wb_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_wb_scoreboard
//  Description : Self-checking bench for fp_wb_scoreboard. Directed scenarios
//                followed by randomized traffic, compared against a
//                behavioural model of the scoreboard and writeback port.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fp_wb_scoreboard;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        issue_valid, issue_wr;
    logic [4:0]  issue_frs, issue_frt, issue_frd;
    logic        issue_stall;
    logic        alu_valid, ld_valid;
    logic [4:0]  alu_dst, ld_dst;
    logic [31:0] alu_data, ld_data;
    logic        alu_ready, ld_ready;
    logic        fp_write;
    logic [4:0]  frd;
    logic [31:0] fp_write_data;
    logic [31:0] busy;
    logic [15:0] conflict_cnt;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit [31:0] m_busy;
    bit        m_fw;
    bit [4:0]  m_frd;
    bit [31:0] m_wd;
    bit        m_alu_turn;   // on contention, ALU goes when set
    int        m_cnt;
    bit        e_stall, e_alu, e_ld;

    fp_wb_scoreboard dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_frs(issue_frs), .issue_frt(issue_frt),
        .issue_frd(issue_frd), .issue_wr(issue_wr), .issue_stall(issue_stall),
        .alu_valid(alu_valid), .alu_dst(alu_dst), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_dst(ld_dst), .ld_data(ld_data), .ld_ready(ld_ready),
        .fp_write(fp_write), .frd(frd), .fp_write_data(fp_write_data),
        .busy(busy), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0; issue_wr = 1'b0;
        issue_frs = 5'd0; issue_frt = 5'd0; issue_frd = 5'd0;
        alu_valid = 1'b0; alu_dst = 5'd0; alu_data = 32'd0;
        ld_valid = 1'b0;  ld_dst = 5'd0;  ld_data = 32'd0;
    endtask

    task automatic model_reset();
        m_busy = '0; m_fw = 1'b0; m_frd = '0; m_wd = '0;
        m_alu_turn = 1'b1; m_cnt = 0;
    endtask

    // Expected combinational responses for the inputs currently applied.
    task automatic model_comb();
        e_stall = issue_valid && (m_busy[issue_frs] || m_busy[issue_frt] ||
                                  (issue_wr && m_busy[issue_frd]));
        if (alu_valid && ld_valid) begin
            e_alu = m_alu_turn;
            e_ld  = !m_alu_turn;
        end else begin
            e_alu = alu_valid;
            e_ld  = ld_valid;
        end
    endtask

    // State after the clock edge, from the rules on pending writes.
    task automatic model_edge();
        bit [31:0] nb;
        nb = m_busy;
        if (m_fw) nb[m_frd] = 1'b0;                      // write retires
        if (issue_valid && !e_stall && issue_wr && issue_frd != 5'd0)
            nb[issue_frd] = 1'b1;                        // new write tracked
        if (alu_valid && ld_valid && m_cnt < 65535) m_cnt = m_cnt + 1;
        if (e_alu) begin
            m_fw = (alu_dst != 5'd0); m_frd = alu_dst; m_wd = alu_data;
            m_alu_turn = 1'b0;
        end else if (e_ld) begin
            m_fw = (ld_dst != 5'd0); m_frd = ld_dst; m_wd = ld_data;
            m_alu_turn = 1'b1;
        end else begin
            m_fw = 1'b0;
        end
        m_busy = nb;
    endtask

    // Called at posedge+1 after inputs are driven; checks combinational outputs.
    task automatic step_comb(input string tag);
        #3;
        model_comb();
        chk({tag, ".stall"},    32'(issue_stall), 32'(e_stall));
        chk({tag, ".alu_rdy"},  32'(alu_ready),   32'(e_alu));
        chk({tag, ".ld_rdy"},   32'(ld_ready),    32'(e_ld));
    endtask

    // Clocks one edge and checks registered outputs.
    task automatic step_edge(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, ".fp_write"}, 32'(fp_write),     32'(m_fw));
        chk({tag, ".frd"},      32'(frd),          32'(m_frd));
        chk({tag, ".wdata"},    fp_write_data,     m_wd);
        chk({tag, ".busy"},     busy,              m_busy);
        chk({tag, ".cnt"},      32'(conflict_cnt), 32'(m_cnt));
    endtask

    task automatic step(input string tag);
        step_comb(tag);
        step_edge(tag);
    endtask

    // Entered at posedge+1; asserts reset away from any edge.
    task automatic do_reset(input string tag);
        #1 reset = 1'b0;
        #1;
        chk({tag, ".busy0"},  busy,                32'd0);
        chk({tag, ".fw0"},    32'(fp_write),       32'd0);
        chk({tag, ".cnt0"},   32'(conflict_cnt),   32'd0);
        chk({tag, ".frd0"},   32'(frd),            32'd0);
        chk({tag, ".wd0"},    fp_write_data,       32'd0);
        chk({tag, ".ardy0"},  32'(alu_ready),      32'd0);
        chk({tag, ".lrdy0"},  32'(ld_ready),       32'd0);
        chk({tag, ".stall0"}, 32'(issue_stall),    32'd0);
        model_reset();
        @(posedge clk);
        #1;
        chk({tag, ".busy_h"}, busy,                32'd0);
        chk({tag, ".fw_h"},   32'(fp_write),       32'd0);
        chk({tag, ".cnt_h"},  32'(conflict_cnt),   32'd0);
        #2 reset = 1'b1;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        #1;
        // Hold requests active during the power-on reset too.
        alu_valid = 1'b1; alu_dst = 5'd2; ld_valid = 1'b1; ld_dst = 5'd3;
        issue_valid = 1'b1; issue_wr = 1'b1; issue_frd = 5'd5;
        do_reset("por");
        idle_inputs();
        @(posedge clk); #1;

        // RAW hazard on $f3 resolved by an ALU writeback
        issue_valid = 1'b1; issue_wr = 1'b1; issue_frd = 5'd3;
        issue_frs = 5'd1; issue_frt = 5'd2;
        step("r27a");
        chk("r27a.busy3", 32'(busy[3]), 32'd1);
        issue_wr = 1'b0; issue_frd = 5'd0; issue_frs = 5'd3; issue_frt = 5'd0;
        alu_valid = 1'b1; alu_dst = 5'd3; alu_data = 32'h4040_0000;
        step_comb("r27b");
        chk("r27b.stall_hi", 32'(issue_stall), 32'd1);
        chk("r27b.alu_rdy",  32'(alu_ready),   32'd1);
        step_edge("r27b");
        chk("r27b.fw_hi",    32'(fp_write),    32'd1);
        chk("r27b.wd",       fp_write_data,    32'h4040_0000);
        alu_valid = 1'b0;
        step_comb("r27c");
        chk("r27c.stall_hi", 32'(issue_stall), 32'd1);
        step_edge("r27c");
        chk("r27c.busy3",    32'(busy[3]),     32'd0);
        step_comb("r27d");
        chk("r27d.stall_lo", 32'(issue_stall), 32'd0);
        step_edge("r27d");
        idle_inputs();

        // Three contention cycles: ALU, LD, ALU
        do_reset("rst28");
        alu_valid = 1'b1; alu_dst = 5'd4; alu_data = 32'hA4;
        ld_valid  = 1'b1; ld_dst  = 5'd5; ld_data  = 32'hB5;
        step_comb("r28a");
        chk("r28a.alu_win", {30'd0, alu_ready, ld_ready}, 32'b10);
        step_edge("r28a");
        alu_dst = 5'd6; alu_data = 32'hA6;
        step_comb("r28b");
        chk("r28b.ld_win", {30'd0, alu_ready, ld_ready}, 32'b01);
        step_edge("r28b");
        chk("r28b.frd5", 32'(frd), 32'd5);
        ld_dst = 5'd7; ld_data = 32'hB7;
        step_comb("r28c");
        chk("r28c.alu_win", {30'd0, alu_ready, ld_ready}, 32'b10);
        step_edge("r28c");
        chk("r28c.frd6", 32'(frd), 32'd6);
        chk("r28c.cnt3", 32'(conflict_cnt), 32'd3);
        idle_inputs();
        step("r28d");

        // Writes to $f0 are never tracked nor committed
        issue_valid = 1'b1; issue_wr = 1'b1; issue_frd = 5'd0;
        step("r29a");
        chk("r29a.busy0", busy, 32'd0);
        idle_inputs();
        ld_valid = 1'b1; ld_dst = 5'd0; ld_data = 32'hDEAD_BEEF;
        step_comb("r29b");
        chk("r29b.ld_rdy", 32'(ld_ready), 32'd1);
        step_edge("r29b");
        chk("r29b.fw_lo", 32'(fp_write), 32'd0);
        ld_valid = 1'b0;
        step("r29c");
        chk("r29c.fw_lo", 32'(fp_write), 32'd0);

        // Same-edge clear and set of $f9 leaves it set
        ld_valid = 1'b1; ld_dst = 5'd9; ld_data = 32'h1234_5678;
        step("r30a");
        chk("r30a.fw9", 32'(fp_write), 32'd1);
        ld_valid = 1'b0;
        issue_valid = 1'b1; issue_wr = 1'b1; issue_frd = 5'd9;
        issue_frs = 5'd1; issue_frt = 5'd2;
        step_comb("r30b");
        chk("r30b.stall_lo", 32'(issue_stall), 32'd0);
        step_edge("r30b");
        chk("r30b.busy9", 32'(busy[9]), 32'd1);
        issue_wr = 1'b0; issue_frd = 5'd0; issue_frt = 5'd9;
        step_comb("r30c");
        chk("r30c.stall_hi", 32'(issue_stall), 32'd1);
        step_edge("r30c");
        idle_inputs();

        // Reset in the middle of a pending write
        do_reset("rst31a");
        issue_valid = 1'b1; issue_wr = 1'b1; issue_frd = 5'd4;
        step("r31a");
        issue_frd = 5'd10;
        step("r31b");
        chk("r31b.busy", busy, 32'h0000_0410);
        issue_valid = 1'b0; issue_wr = 1'b0;
        alu_valid = 1'b1; alu_dst = 5'd12; alu_data = 32'hC0C0;
        ld_valid  = 1'b1; ld_dst  = 5'd13; ld_data  = 32'hD0D0;
        step("r31c");
        chk("r31c.fw_pend", 32'(fp_write), 32'd1);
        do_reset("rst31b");
        step_comb("r31d");
        chk("r31d.alu_win", {30'd0, alu_ready, ld_ready}, 32'b10);
        step_edge("r31d");
        idle_inputs();

        // Randomized traffic; stalled/ungranted requests are held stable
        for (int i = 0; i < 400; i++) begin
            issue_valid = 1'($urandom_range(0, 1));
            issue_wr    = 1'($urandom_range(0, 1));
            issue_frs   = 5'($urandom_range(0, 15));
            issue_frt   = 5'($urandom_range(0, 15));
            issue_frd   = 5'($urandom_range(0, 15));
            if (!(alu_valid && !e_alu)) begin
                alu_valid = ($urandom_range(0, 2) != 0);
                alu_dst   = 5'($urandom_range(0, 15));
                alu_data  = $urandom;
            end
            if (!(ld_valid && !e_ld)) begin
                ld_valid = ($urandom_range(0, 2) != 0);
                ld_dst   = 5'($urandom_range(0, 15));
                ld_data  = $urandom;
            end
            step("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
